fetch_stage: RTL and testbench

Instruction fetch stage of the 16-bit pipelined processor. It drives a synchronous-read instruction memory, buffers returned words in a small prefetch queue, and presents one instruction per cycle to decode with a valid/stall handshake. It handles branch redirects, flushing stale fetches. Fetching halts after the all-zero instruction (the program terminator) is fetched.

---
 rtl/fetch_stage_if.sv | 42 ++++
 rtl/fetch_stage.sv | 95 +++++++++
 tb/tb_fetch_stage.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction memory port plus
// the decode-side valid/stall and redirect signals.
interface fetch_stage_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_rd_en;
  logic [15:0]       imem_rdata;
  logic [15:0]       instr_d;
  logic [ADDR_W-1:0] pc_d;
  logic              valid_d;
  logic              stall_d;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic              halted;

  modport master (
    output imem_addr,
    output imem_rd_en,
    input  imem_rdata,
    output instr_d,
    output pc_d,
    output valid_d,
    input  stall_d,
    input  branch_taken,
    input  branch_target,
    output halted
  );

  modport slave (
    input  imem_addr,
    input  imem_rd_en,
    output imem_rdata,
    input  instr_d,
    input  pc_d,
    input  valid_d,
    output stall_d,
    output branch_taken,
    output branch_target,
    input  halted
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: sync-read imem driver, prefetch
// queue, redirect flush and halt on zero instruction.
module fetch_stage #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
) (
  input logic          clk,
  input logic          reset,
  fetch_stage_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {RUN, HALT} state_t;

  typedef struct packed {
    logic [15:0]       instr;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  state_t            state;
  entry_t            q [DEPTH];
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CW-1:0]     count;
  logic              inflight;
  logic              drop;

  logic issue;
  logic push;
  logic pop;
  logic term;
  logic valid;
  logic redir;

  assign redir = bus.branch_taken;
  assign valid = count != '0;

  // Space is reserved at issue time, so a push never overflows.
  assign issue = reset && state == RUN && !redir
              && (count + CW'(inflight)) < CW'(DEPTH);

  assign push = inflight && !drop && !redir;
  assign term = push && bus.imem_rdata == 16'h0000;
  assign pop  = valid && !bus.stall_d && !redir;

  assign bus.imem_addr  = pc;
  assign bus.imem_rd_en = issue;
  assign bus.valid_d    = valid;
  assign bus.instr_d    = valid ? q[head].instr : '0;
  assign bus.pc_d       = valid ? q[head].pc : '0;
  assign bus.halted     = state == HALT;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      pc          <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      drop        <= 1'b0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
    end else begin
      inflight <= issue;
      drop     <= issue && term;
      if (issue) begin
        pc          <= pc + ADDR_W'(1);
        inflight_pc <= pc;
      end
      if (redir) begin
        pc    <= bus.branch_target;
        head  <= '0;
        tail  <= '0;
        count <= '0;
        state <= RUN;
      end else begin
        if (push) tail <= tail + PW'(1);
        if (pop) head <= head + PW'(1);
        count <= count + CW'(push) - CW'(pop);
        if (term) state <= HALT;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else if (push) begin
      q[tail] <= '{instr: bus.imem_rdata, pc: inflight_pc};
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// Randomised and directed bench for fetch_stage
// against a sequential-stream reference model.
module tb_fetch_stage;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fetch_stage_if #(.ADDR_W(8)) bus();

  fetch_stage #(.ADDR_W(8), .DEPTH(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [15:0] mem [256];

  always @(posedge clk)
    if (bus.imem_rd_en) bus.imem_rdata <= mem[bus.imem_addr];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // Decode must see mem[t], mem[t+1], ... from the last
  // reset (t=0) or redirect, up to and including a zero.
  logic [7:0]  exp_pc;
  bit          done;
  bit          pst;
  logic [15:0] pin;
  logic [7:0]  ppc;

  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      exp_pc = 8'h00;
      done   = 1'b0;
      pst    = 1'b0;
    end else if (bus.branch_taken) begin
      exp_pc = bus.branch_target;
      done   = 1'b0;
      pst    = 1'b0;
    end else begin
      if (pst) begin
        chk("hold_valid", bus.valid_d, 1);
        chk("hold_instr", bus.instr_d, pin);
        chk("hold_pc", bus.pc_d, ppc);
      end
      if (bus.halted)
        chk("halt_no_issue", bus.imem_rd_en, 0);
      if (bus.valid_d && !bus.stall_d) begin
        if (done) begin
          chk("after_term_valid", bus.valid_d, 0);
        end else begin
          chk("stream_pc", bus.pc_d, exp_pc);
          chk("stream_instr", bus.instr_d, mem[exp_pc]);
          if (mem[exp_pc] == 16'h0000) done = 1'b1;
          exp_pc = exp_pc + 8'd1;
        end
      end
      pst = bus.valid_d && bus.stall_d;
      pin = bus.instr_d;
      ppc = bus.pc_d;
    end
  end

  task automatic wait_valid(input int n, input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < n && !ok; i++) begin
      @(negedge clk);
      ok = bus.valid_d;
    end
    chk(nm, ok, 1);
  endtask

  task automatic wait_halt(input int n, input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < n && !ok; i++) begin
      @(negedge clk);
      ok = bus.halted;
    end
    chk(nm, ok, 1);
  endtask

  task automatic redirect(input logic [7:0] t);
    @(posedge clk);
    #1;
    bus.branch_taken  = 1'b1;
    bus.branch_target = t;
    @(posedge clk);
    #1;
    bus.branch_taken = 1'b0;
  endtask

  logic [15:0] exp1 [4];
  logic [7:0]  wexp [3];
  int          first_rd;
  int          first_v;
  int          n;
  logic [15:0] got_i [$];
  logic [7:0]  got_p [$];
  int          got_c [$];

  initial begin
    exp1 = '{16'h1111, 16'h2222, 16'h3333, 16'h0000};
    wexp = '{8'hFE, 8'hFF, 8'h00};
    bus.stall_d       = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
    mem[0]     = 16'h1111;
    mem[1]     = 16'h2222;
    mem[2]     = 16'h3333;
    mem[3]     = 16'h0000;
    mem[8'h48] = 16'h0000;

    // asynchronous reset, no clock edge yet
    #2 reset = 1'b0;
    #1;
    chk("rst_addr", bus.imem_addr, 0);
    chk("rst_rd_en", bus.imem_rd_en, 0);
    chk("rst_instr", bus.instr_d, 0);
    chk("rst_pc", bus.pc_d, 0);
    chk("rst_valid", bus.valid_d, 0);
    chk("rst_halted", bus.halted, 0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;

    // program 1111,2222,3333,0000
    first_rd = -1;
    first_v  = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.imem_rd_en && first_rd < 0) first_rd = c;
      if (bus.valid_d) begin
        if (first_v < 0) first_v = c;
        got_i.push_back(bus.instr_d);
        got_p.push_back(bus.pc_d);
        got_c.push_back(c);
      end
    end
    chk("first_rd_cycle", first_rd, 0);
    chk("fetch_latency", first_v - first_rd, 2);
    chk("t1_count", got_i.size(), 4);
    for (int k = 0; k < got_i.size() && k < 4; k++) begin
      chk("t1_instr", got_i[k], exp1[k]);
      chk("t1_pc", got_p[k], k);
      chk("t1_back2back", got_c[k] - got_c[0], k);
    end
    chk("t1_halted", bus.halted, 1);
    chk("t1_rd_en", bus.imem_rd_en, 0);
    chk("t1_valid", bus.valid_d, 0);

    // stall for 8 cycles from first valid
    redirect(8'h20);
    wait_valid(10, "t2_first_valid");
    @(posedge clk);
    #1 bus.stall_d = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("t2_full_rd_en", bus.imem_rd_en, 0);
    chk("t2_full_valid", bus.valid_d, 1);
    @(posedge clk);
    #1 bus.stall_d = 1'b0;
    @(negedge clk);
    chk("t2_pop_cycle_rd_en", bus.imem_rd_en, 0);
    @(negedge clk);
    chk("t2_next_rd_en", bus.imem_rd_en, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t2_no_gap", bus.valid_d, 1);
    end

    // redirect with 3 queued and one read in flight
    @(posedge clk);
    #1;
    bus.stall_d       = 1'b1;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 8'h30;
    @(posedge clk);
    #1 bus.branch_taken = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("t3_full_rd_en", bus.imem_rd_en, 0);
    chk("t3_valid", bus.valid_d, 1);
    bus.branch_taken  = 1'b1;
    bus.branch_target = 8'h40;
    bus.stall_d       = 1'b0;
    @(posedge clk);
    #1 bus.branch_taken = 1'b0;
    @(negedge clk);
    chk("t3_valid_n1", bus.valid_d, 0);
    chk("t3_rd_en_n1", bus.imem_rd_en, 1);
    chk("t3_addr_n1", bus.imem_addr, 8'h40);
    @(negedge clk);
    chk("t3_valid_n2", bus.valid_d, 0);
    @(negedge clk);
    chk("t3_valid_n3", bus.valid_d, 1);
    chk("t3_pc_n3", bus.pc_d, 8'h40);

    // redirect while halted
    wait_halt(40, "t4_halted");
    chk("t4_halt_rd_en", bus.imem_rd_en, 0);
    redirect(8'h10);
    @(negedge clk);
    chk("t4_unhalted", bus.halted, 0);
    chk("t4_rd_en", bus.imem_rd_en, 1);
    chk("t4_addr", bus.imem_addr, 8'h10);

    // reset mid-stream, read in flight
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("t5_pre_valid", bus.valid_d, 1);
    #1 reset = 1'b0;
    #1;
    chk("t5_addr", bus.imem_addr, 0);
    chk("t5_rd_en", bus.imem_rd_en, 0);
    chk("t5_instr", bus.instr_d, 0);
    chk("t5_pc", bus.pc_d, 0);
    chk("t5_valid", bus.valid_d, 0);
    chk("t5_halted", bus.halted, 0);
    #1 reset = 1'b1;
    wait_valid(10, "t5_first_valid");
    chk("t5_first_pc", bus.pc_d, 0);
    chk("t5_first_instr", bus.instr_d, 16'h1111);

    // wrap through 0xFF
    wait_halt(20, "t6_halted");
    redirect(8'hFE);
    n = 0;
    for (int i = 0; i < 20 && n < 3; i++) begin
      @(negedge clk);
      if (bus.valid_d && !bus.stall_d) begin
        chk("t6_wrap_pc", bus.pc_d, wexp[n]);
        n++;
      end
    end
    chk("t6_wrap_count", n, 3);

    // random phase
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 256; i++)
      mem[i] = ($urandom_range(0, 15) == 0) ? 16'h0000
             : 16'($urandom_range(1, 16'hFFFF));
    @(posedge clk);
    #1 reset = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      bus.stall_d = $urandom_range(0, 99) < 30;
      bus.branch_taken = ($urandom_range(0, 99) < 4)
        || (bus.halted && $urandom_range(0, 99) < 20);
      bus.branch_target = 8'($urandom_range(0, 255));
    end
    @(posedge clk);
    #1;
    bus.branch_taken = 1'b0;
    bus.stall_d      = 1'b0;
    repeat (4) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
